mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-client arbiter that shares the single backing-memory block port between two cache controllers, e.g. I-cache and D-cache, or two cache instances.
- Each client issues whole-block reads (refill) or writes (eviction write-back).
- The arbiter serialises these, drives the memory handshake and returns completion and read data to the owning client.
- Sits between the cache control FSMs and the memory model.

Parameters:
- PA_WIDTH, 32, physical address width.
- BLK_WIDTH, 128, cache block width in bits, equal to the memory transfer width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- c_req  in  2  per-client request, level; bit i belongs to client i.
- c_we  in  2  per-client op: 1 = block write, 0 = block read.
- c0_addr  in  PA_WIDTH  client 0 block address.
- c1_addr  in  PA_WIDTH  client 1 block address.
- c0_wblk  in  BLK_WIDTH  client 0 write block.
- c1_wblk  in  BLK_WIDTH  client 1 write block.
- c_done  out  2  per-client one-cycle completion pulse.
- c_rblk  out  BLK_WIDTH  read block; valid while c_done is nonzero.
- c_err  out  2  per-client error pulse; only used with the optional feature.
- busy  out  1  transaction in flight.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  memory op: 1 = write, 0 = read.
- mem_addr  out  PA_WIDTH  memory address.
- mem_wblk  out  BLK_WIDTH  memory write data.
- mem_ack  in  1  memory completion; single-cycle pulse.
- mem_rblk  in  BLK_WIDTH  memory read data; valid with mem_ack.

Behaviour:
- All outputs are registered.
- Reset values: c_done=0, c_err=0, c_rblk=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wblk=0, state=IDLE, prio=0.
- Reset is asynchronous. A reset mid-transaction drops mem_req immediately and issues no done pulse.
- Client rule: a client holds req, we, addr and wblk stable from req assertion until its c_done or c_err pulse. It deasserts req in the following cycle unless it is presenting a new request.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If c_req is 0: stay in IDLE.
  - If exactly one bit is set: grant that client.
  - If both bits are set: grant client prio.
  - On grant: latch the id; copy we/addr/wblk to mem_we/mem_addr/mem_wblk; set mem_req=1 and busy=1; go to BUSY.
  - Latency: mem_req rises the cycle after req is first seen in IDLE.
- BUSY:
  - mem_req stays at 1.
  - On mem_ack: set mem_req=0. For a read, capture mem_rblk into c_rblk; for a write, c_rblk keeps its previous value. Go to RESP.
  - mem_ack is allowed in the first BUSY cycle.
- RESP:
  - c_done[id]=1 for exactly this cycle.
  - Set busy=0 and prio=~id.
  - Go to IDLE.
  - The next grant is sampled in the IDLE cycle that follows, so the minimum spacing between back-to-back mem_req rises is 3 cycles with an immediate ack.
- In IDLE, a stale c_req from the client just completed is treated as a new request. Clients must deassert per the client rule.
- mem_ack outside BUSY is ignored.
- The c_req/c_we bit of the client not being served is ignored while in BUSY or RESP.
- Fairness: prio toggles only after a completed grant. With both clients requesting continuously, grants alternate 0,1,0,1…
- A lone requester is never blocked by prio.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit watchdog clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When it reaches 255: mem_req=0, c_err[id]=1 for one cycle, no c_done, prio=~id, busy=0; go to IDLE next cycle.
  - A mem_ack in the same cycle as expiry wins and completes normally.
- Disabled: no counter; c_err is tied to 0; BUSY waits indefinitely.

Test Plan:
- Reset, then client 0 read at addr 0x0000_0040; memory acks 2 cycles after mem_req with rblk 0xDEAD…BEEF. Required: mem_req high for 3 cycles with mem_we=0 and mem_addr=0x40; then c_done=2'b01 for 1 cycle with c_rblk=0xDEAD…BEEF.
- Both clients request in the same cycle (c0 write to 0x100, c1 read from 0x200). Required: client 0 is served first (prio=0), then client 1. c_done pulses 01 then 10, and mem_addr sequence is 0x100, 0x200.
- Both clients hold requests continuously with immediate ack for 6 transactions. Required: grant order 0,1,0,1,0,1, with mem_req rises spaced 3 cycles apart.
- Client 1 alone requests while prio=0. Required: granted the cycle after request; prio becomes 0 after completion.
- Assert rst_n=0 during BUSY. Required: mem_req=0 immediately; no c_done; after release, a pending c_req is regranted from IDLE.
- With MEM_ARB_TIMEOUT_EN and no mem_ack: c_err[id] pulses once; mem_req falls; the other client's request is then granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-client block-transfer arbiter sharing one memory port; round-robin on contention, registered outputs.
// Define MEM_ARB_TIMEOUT_EN to add an 8-bit BUSY watchdog that aborts a stalled transfer with c_err.
module mem_port_arbiter #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           c_req,
  input  logic [1:0]           c_we,
  input  logic [PA_WIDTH-1:0]  c0_addr,
  input  logic [PA_WIDTH-1:0]  c1_addr,
  input  logic [BLK_WIDTH-1:0] c0_wblk,
  input  logic [BLK_WIDTH-1:0] c1_wblk,
  output logic [1:0]           c_done,
  output logic [BLK_WIDTH-1:0] c_rblk,
  output logic [1:0]           c_err,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic [BLK_WIDTH-1:0] mem_wblk,
  input  logic                 mem_ack,
  input  logic [BLK_WIDTH-1:0] mem_rblk
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 id_q, id_d;
  logic                 prio_q, prio_d;
  logic [1:0]           c_done_q, c_done_d;
  logic [BLK_WIDTH-1:0] c_rblk_q, c_rblk_d;
  logic                 busy_q, busy_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [PA_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [BLK_WIDTH-1:0] mem_wblk_q, mem_wblk_d;
  logic                 gnt;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [1:0]           c_err_q, c_err_d;
  logic [7:0]           wdog_q, wdog_d;
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    prio_d     = prio_q;
    c_done_d   = 2'b00;
    c_rblk_d   = c_rblk_q;
    busy_d     = busy_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wblk_d = mem_wblk_q;
    gnt        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    c_err_d    = 2'b00;
    wdog_d     = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (c_req != 2'b00) begin
          // prio only matters on contention; a lone requester always wins
          gnt        = (c_req == 2'b11) ? prio_q : c_req[1];
          id_d       = gnt;
          mem_we_d   = c_we[gnt];
          mem_addr_d = gnt ? c1_addr : c0_addr;
          mem_wblk_d = gnt ? c1_wblk : c0_wblk;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          wdog_d     = 8'd0;
`endif
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) c_rblk_d = mem_rblk;
          c_done_d  = id_q ? 2'b10 : 2'b01;
          state_d   = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wdog_q == 8'hFF) begin
          mem_req_d = 1'b0;
          c_err_d   = id_q ? 2'b10 : 2'b01;
          prio_d    = ~id_q;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      RESP: begin
        busy_d  = 1'b0;
        prio_d  = ~id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      prio_q     <= 1'b0;
      c_done_q   <= 2'b00;
      c_rblk_q   <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wblk_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      c_err_q    <= 2'b00;
      wdog_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      prio_q     <= prio_d;
      c_done_q   <= c_done_d;
      c_rblk_q   <= c_rblk_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wblk_q <= mem_wblk_d;
`ifdef MEM_ARB_TIMEOUT_EN
      c_err_q    <= c_err_d;
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign c_done   = c_done_q;
  assign c_rblk   = c_rblk_q;
  assign busy     = busy_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wblk = mem_wblk_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign c_err    = c_err_q;
`else
  assign c_err    = 2'b00;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard queues for client responses and memory requests.
module tb_mem_port_arbiter;
  localparam int PA = 32;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    c_req = 2'b00;
  logic [1:0]    c_we = 2'b00;
  logic [PA-1:0] c0_addr = '0;
  logic [PA-1:0] c1_addr = '0;
  logic [BW-1:0] c0_wblk = '0;
  logic [BW-1:0] c1_wblk = '0;
  logic [1:0]    c_done;
  logic [BW-1:0] c_rblk;
  logic [1:0]    c_err;
  logic          busy;
  logic          mem_req;
  logic          mem_we;
  logic [PA-1:0] mem_addr;
  logic [BW-1:0] mem_wblk;
  logic          mem_ack = 1'b0;
  logic [BW-1:0] mem_rblk = '0;

  mem_port_arbiter #(.PA_WIDTH(PA), .BLK_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .c_req(c_req), .c_we(c_we),
    .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wblk(c0_wblk), .c1_wblk(c1_wblk),
    .c_done(c_done), .c_rblk(c_rblk), .c_err(c_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wblk(mem_wblk),
    .mem_ack(mem_ack), .mem_rblk(mem_rblk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    done;
    logic [1:0]    err;
    logic [BW-1:0] rblk;
  } resp_t;

  typedef struct {
    logic          we;
    logic [PA-1:0] addr;
    logic [BW-1:0] wblk;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: 0x40 holds the DEAD..BEEF pattern, everything else {4{addr ^ A5A50000}}.
  function automatic logic [BW-1:0] mdata(input logic [PA-1:0] a);
    if (a == 32'h40) return {4{32'hDEADBEEF}};
    return {4{a ^ 32'hA5A5_0000}};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model and request monitor. Address 0xBAD0 is never acknowledged.
  int   ack_dly = 0;
  int   mcnt = 0;
  int   hi_len = 0;
  int   last_hi = 0;
  int   last_rise = -1;
  bit   chk_space = 0;
  logic mreq_prev = 1'b0;
  mreq_t me;

  always @(posedge clk) begin
    #1;
    mem_ack  = 1'b0;
    mem_rblk = {4{32'h5555_AAAA}};
    if (mem_req && !mreq_prev) begin
      if (mreq_q.size() == 0) begin
        total++; bad++;
        $display("FAIL mem_unexpected: mem_req rose with addr %0h, none expected", mem_addr);
      end else begin
        me = mreq_q.pop_front();
        chk("mem_we", mem_we, me.we);
        chk("mem_addr", mem_addr, me.addr);
        if (me.we) chk("mem_wblk", mem_wblk, me.wblk);
      end
      if (chk_space && last_rise >= 0) chk("rise_spacing", cyc - last_rise, 3);
      last_rise = cyc;
    end
    if (mem_req) begin
      hi_len++;
      if (mem_addr != 32'hBAD0) begin
        if (mcnt == ack_dly) begin
          mem_ack  = 1'b1;
          mem_rblk = mdata(mem_addr);
          mcnt     = 0;
        end else begin
          mcnt++;
        end
      end
    end else begin
      if (mreq_prev) last_hi = hi_len;
      hi_len = 0;
      mcnt   = 0;
    end
    mreq_prev = mem_req;
  end

  // Response monitor: every done/err pulse must match the next expected entry.
  resp_t mr;
  always @(posedge clk) begin
    #1;
    if ((c_done | c_err) != 2'b00) begin
      if (resp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: done=%b err=%b, none expected", c_done, c_err);
      end else begin
        mr = resp_q.pop_front();
        chk("c_done", c_done, mr.done);
        chk("c_err", c_err, mr.err);
        chk("c_rblk", c_rblk, mr.rblk);
      end
    end
  end

  task automatic push_m(input logic we, input logic [PA-1:0] a, input logic [BW-1:0] w);
    mreq_t m;
    m.we = we; m.addr = a; m.wblk = w;
    mreq_q.push_back(m);
  endtask

  task automatic push_r(input logic [1:0] d, input logic [1:0] e, input logic [BW-1:0] rb);
    resp_t r;
    r.done = d; r.err = e; r.rblk = rb;
    resp_q.push_back(r);
  endtask

  task automatic issue(input int c, input logic we, input logic [PA-1:0] a, input logic [BW-1:0] w);
    if (c == 0) begin c0_addr = a; c0_wblk = w; end
    else begin c1_addr = a; c1_wblk = w; end
    c_we[c]  = we;
    c_req[c] = 1'b1;
  endtask

  task automatic wait_resp(input int c, input int limit);
    int n = 0;
    bit got = 0;
    while (!got && n < limit) begin
      @(posedge clk); #2;
      n++;
      if (c_done[c] || c_err[c]) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wait_resp%0d: no completion within %0d cycles", c, limit);
    end
    c_req[c] = 1'b0;
  endtask

  task automatic do_req(input int c, input logic we, input logic [PA-1:0] a, input logic [BW-1:0] w);
    issue(c, we, a, w);
    wait_resp(c, 50);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    c_req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_c_done", c_done, 2'b00);
    chk("rst_c_err", c_err, 2'b00);
    chk("rst_c_rblk", c_rblk, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wblk", mem_wblk, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;

    // client 0 read, ack two cycles after mem_req
    ack_dly = 2;
    push_m(1'b0, 32'h40, '0);
    push_r(2'b01, 2'b00, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    do_req(0, 1'b0, 32'h40, '0);
    @(posedge clk); #2;
    chk("t1_mem_req_len", last_hi, 3);

    // lone client 1 after reset (prio=0) is granted next cycle
    apply_reset();
    ack_dly = 0;
    push_m(1'b0, 32'h500, '0);
    push_r(2'b10, 2'b00, 128'hA5A50500_A5A50500_A5A50500_A5A50500);
    issue(1, 1'b0, 32'h500, '0);
    @(posedge clk); #2;
    chk("t4_grant_latency", mem_req, 1'b1);
    chk("t4_busy", busy, 1'b1);
    wait_resp(1, 50);

    // simultaneous: c0 write first (prio back to 0), then c1 read; write keeps c_rblk
    ack_dly = 1;
    push_m(1'b1, 32'h100, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    push_m(1'b0, 32'h200, '0);
    push_r(2'b01, 2'b00, 128'hA5A50500_A5A50500_A5A50500_A5A50500);
    push_r(2'b10, 2'b00, 128'hA5A50200_A5A50200_A5A50200_A5A50200);
    fork
      do_req(0, 1'b1, 32'h100, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
      do_req(1, 1'b0, 32'h200, '0);
    join

    // continuous contention, immediate ack: 0,1,0,1,0,1 with rises 3 cycles apart
    ack_dly   = 0;
    chk_space = 1;
    last_rise = -1;
    for (int i = 0; i < 3; i++) begin
      push_m(1'b0, 32'h1000 + 32'(i * 64), '0);
      push_m(1'b0, 32'h2000 + 32'(i * 64), '0);
      push_r(2'b01, 2'b00, mdata(32'h1000 + 32'(i * 64)));
      push_r(2'b10, 2'b00, mdata(32'h2000 + 32'(i * 64)));
    end
    fork
      for (int i = 0; i < 3; i++) do_req(0, 1'b0, 32'h1000 + 32'(i * 64), '0);
      for (int j = 0; j < 3; j++) do_req(1, 1'b0, 32'h2000 + 32'(j * 64), '0);
    join
    chk_space = 0;

    // reset during BUSY: mem_req drops at once, no done, pending request regranted
    ack_dly = 5;
    push_m(1'b0, 32'h300, '0);
    issue(0, 1'b0, 32'h300, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_req", mem_req, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_c_done", c_done, 2'b00);
    ack_dly = 1;
    push_m(1'b0, 32'h300, '0);
    push_r(2'b01, 2'b00, 128'hA5A50300_A5A50300_A5A50300_A5A50300);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_resp(0, 50);

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog: c0 never acked -> c_err 01, then c1 served
    apply_reset();
    ack_dly = 0;
    push_m(1'b0, 32'hBAD0, '0);
    push_m(1'b0, 32'h400, '0);
    push_r(2'b00, 2'b01, '0);
    push_r(2'b10, 2'b00, 128'hA5A50400_A5A50400_A5A50400_A5A50400);
    fork
      begin issue(0, 1'b0, 32'hBAD0, '0); wait_resp(0, 600); end
      begin issue(1, 1'b0, 32'h400, '0); wait_resp(1, 600); end
    join
`endif

    repeat (4) @(posedge clk);
    #2;
    chk("resp_q_drained", resp_q.size(), 0);
    chk("mreq_q_drained", mreq_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
